// File: rtl/hdpldadapt_cmn_occ_burst_monitor_if.sv
// Observation bus between the OCC capture path / test controller and the burst monitor.
// master = test side (drives scan/OCC observations), slave = the monitor.
interface hdpldadapt_cmn_occ_burst_monitor_if #(
  parameter int ERR_CNT_WIDTH = 8
);
  logic                     scan_enable;
  logic                     occ_enable;
  logic                     atpg_mode;
  logic [1:0]               burst_cnt;
  logic                     occ_user_clken;
  logic [2:0]               pulse_cnt;
  logic                     burst_done;
  logic                     burst_err;
  logic                     err_sticky;
  logic                     leak_err;
  logic [ERR_CNT_WIDTH-1:0] err_count;

  modport master (
    output scan_enable, occ_enable, atpg_mode, burst_cnt, occ_user_clken,
    input  pulse_cnt, burst_done, burst_err, err_sticky, leak_err, err_count
  );

  modport slave (
    input  scan_enable, occ_enable, atpg_mode, burst_cnt, occ_user_clken,
    output pulse_cnt, burst_done, burst_err, err_sticky, leak_err, err_count
  );
endinterface

// File: rtl/hdpldadapt_cmn_occ_burst_monitor.sv
// OCC capture burst monitor: counts delivered user-clock enable pulses per capture window.
// Optional mismatch counter enabled by defining HDPLDADAPT_OCC_MON_ERR_CNT_EN.
//
// state | meaning
// IDLE  | shift / waiting for a capture start; watches for clock-enable leaks
// COUNT | capture window open, counting occ_user_clken pulses
// CHECK | window closed, publish count and compare against latched burst_cnt
module hdpldadapt_cmn_occ_burst_monitor #(
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT       = 16,
  parameter int ERR_CNT_WIDTH = 8
) (
  input logic                                 user_clk,
  input logic                                 rst_n,
  hdpldadapt_cmn_occ_burst_monitor_if.slave   mon
);

  localparam int              TMO_W    = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, COUNT, CHECK} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] se_sync;
  logic                   se_s;
  logic                   se_d;
  logic                   active;
  logic                   cap_start;
  logic                   mismatch;
  logic [2:0]             cnt;
  logic [1:0]             exp_q;
  logic [TMO_W-1:0]       tmo;
  logic [2:0]             pulse_cnt_q;
  logic                   burst_done_q;
  logic                   burst_err_q;
  logic                   err_sticky_q;
  logic                   leak_err_q;

  // Synchronizer resets to shift so reset release never looks like a falling scan_enable.
  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      se_sync <= '1;
      se_d    <= 1'b1;
    end else begin
      se_sync <= {se_sync[SYNC_STAGES-2:0], mon.scan_enable};
      se_d    <= se_s;
    end
  end

  assign se_s      = se_sync[SYNC_STAGES-1];
  assign active    = mon.atpg_mode & mon.occ_enable;
  assign cap_start = se_d & ~se_s;
  assign mismatch  = (cnt != {1'b0, exp_q});

  // Timeout is a down-counter loaded at window start; terminal count forces the check.
  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      exp_q        <= 2'd0;
      tmo          <= '0;
      pulse_cnt_q  <= 3'd0;
      burst_done_q <= 1'b0;
      burst_err_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      leak_err_q   <= 1'b0;
    end else begin
      burst_done_q <= 1'b0;
      burst_err_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (active) begin
            if (se_s && mon.occ_user_clken) begin
              leak_err_q   <= 1'b1;
              err_sticky_q <= 1'b1;
            end
            if (cap_start) begin
              state <= COUNT;
              exp_q <= mon.burst_cnt;
              cnt   <= 3'd0;
              tmo   <= TMO_LOAD;
            end
          end
        end
        COUNT: begin
          if (!active) begin
            state <= IDLE;
          end else begin
            if (mon.occ_user_clken && (cnt != 3'd7)) cnt <= cnt + 3'd1;
            tmo <= tmo - 1'b1;
            if (se_s || (tmo == '0)) state <= CHECK;
          end
        end
        CHECK: begin
          state <= IDLE;
          if (active) begin
            pulse_cnt_q  <= cnt;
            burst_done_q <= 1'b1;
            burst_err_q  <= mismatch;
            if (mismatch) err_sticky_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HDPLDADAPT_OCC_MON_ERR_CNT_EN
  logic [ERR_CNT_WIDTH-1:0] err_count_q;

  always_ff @(posedge user_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_q <= '0;
    end else if ((state == CHECK) && active && mismatch && (err_count_q != '1)) begin
      err_count_q <= err_count_q + 1'b1;
    end
  end

  assign mon.err_count = err_count_q;
`else
  assign mon.err_count = {ERR_CNT_WIDTH{1'b0}};
`endif

  assign mon.pulse_cnt  = pulse_cnt_q;
  assign mon.burst_done = burst_done_q;
  assign mon.burst_err  = burst_err_q;
  assign mon.err_sticky = err_sticky_q;
  assign mon.leak_err   = leak_err_q;

endmodule
